store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the CPU load/store path and DataMemory. Stores
//  are queued in a small FIFO and drained to DataMemory one per cycle when the
//  CPU is not loading. Loads are served combinationally, from the newest
//  matching buffered store if one exists, otherwise from DataMemory. Sits
//  directly upstream of DataMemory and owns its a/din/mwrite/mread inputs.
// PARAMETERS
//  S  32   data word width, bits
//  L  256  memory length in words; address width AW = $clog2(L)
//  D  4    buffer depth in entries (power of 2, >= 2)
// PORTS
//  clk         in   1         clock; all state updates on posedge
//  reset       in   1         asynchronous, active-high; clears the buffer
//  cpu_a       in   AW        CPU word address
//  cpu_din     in   S         CPU store data
//  cpu_mread   in   1         CPU load request, this cycle
//  cpu_mwrite  in   1         CPU store request, this cycle
//  cpu_dout    out  S         load data to CPU (combinational)
//  stall       out  1         store not accepted this cycle; CPU must hold
//  mem_a       out  AW        to DataMemory a
//  mem_din     out  S         to DataMemory din
//  mem_mread   out  1         to DataMemory mread
//  mem_mwrite  out  1         to DataMemory mwrite
//  mem_dout    in   S         from DataMemory dout (combinational read)
//  empty       out  1         buffer holds no entries
//  count       out  $clog2(D)+1  number of valid entries
// BEHAVIOUR
//  - Storage: D entries {addr, data} in a circular FIFO with head/tail pointers
//    that wrap modulo D, plus a count register (0..D). No coalescing: each
//    accepted store occupies its own entry.
//  - Reset (async, immediate): count=0, head=tail=0, all entries invalid.
//    Outputs: empty=1, count=0, stall=0, mem_mwrite=0, mem_mread=0, mem_a=0,
//    mem_din=0. Buffered stores are discarded, never written to memory.
//  - Port arbitration, per cycle, combinational:
//    * LOAD  (cpu_mread=1): mem_a=cpu_a, mem_mread=1, mem_mwrite=0.
//      No drain this cycle.
//    * DRAIN (cpu_mread=0, count>0): mem_a=head.addr, mem_din=head.data,
//      mem_mwrite=1. The head pops at posedge.
//    * IDLE: mem_a=0, mem_din=0, mem_mwrite=0, mem_mread=0.
//  - Push: when cpu_mwrite=1 and count<D, {cpu_a, cpu_din} is written at the
//    tail at posedge. stall = cpu_mwrite & (count==D), combinational; the push
//    is rejected even if a pop happens in the same cycle. The CPU retries the
//    next cycle, by which time the drain has freed a slot, unless it is loading.
//  - Push and pop in the same cycle: count is unchanged; head and tail both advance.
//  - Load data: cpu_dout = data of the newest valid entry with addr==cpu_a
//    (search from tail-1 back to head), else mem_dout. The search covers only
//    entries present before this cycle's posedge. With cpu_mread and
//    cpu_mwrite both set, the load returns the pre-store value and the store
//    is pushed normally.
//  - When cpu_mread=0, cpu_dout = mem_dout, which is don't-care for the CPU.
//  - Memory order: drains follow FIFO order, so DataMemory ends up holding the
//    newest value for every address once the buffer is empty.
//  - empty = (count==0). Latency: a store reaches DataMemory no earlier than
//    1 cycle after acceptance; a load with cpu_mread held is never delayed.
// TESTING
//  1 Reset mid-drain with 3 entries queued -> count=0, empty=1, mem_mwrite=0
//    at once; those 3 addresses keep their old values in DataMemory.
//  2 Store 0xAAAA_0001 @0x10, then a load @0x10 next cycle -> cpu_dout=0xAAAA_0001
//    (forwarded); memory is written after the load releases the port.
//  3 Stores @0x20 of 0x1, then 0x2, then 0x3 while cpu_mread is held on another
//    address; then a load @0x20 -> 0x3. After the drain, DataMemory[0x20]=0x3.
//  4 D=4: fill 4 entries with cpu_mread=1, then store #5 -> stall=1, count=4;
//    release cpu_mread -> one drain, store #5 accepted next cycle, count=4.
//  5 Sustained store every cycle with no loads -> stall never 1, count stays 1,
//    and mem_a follows the stored addresses 1 cycle later.
//  6 Wrap-around: 10 push/pop cycles with D=4 -> FIFO order preserved;
//    final DataMemory contents match a reference array model.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO sitting in front of DataMemory.
// CPU stores are queued and drained one per cycle whenever the CPU is not
// loading; loads are answered combinationally, forwarding the newest queued
// store to the same address ahead of DataMemory contents.
module store_buffer #(
    parameter int S  = 32,
    parameter int L  = 256,
    parameter int D  = 4,
    localparam int AW = $clog2(L),
    localparam int PW = $clog2(D),
    localparam int CW = $clog2(D) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_a,
    input  logic [S-1:0]  cpu_din,
    input  logic          cpu_mread,
    input  logic          cpu_mwrite,
    output logic [S-1:0]  cpu_dout,
    output logic          stall,
    output logic [AW-1:0] mem_a,
    output logic [S-1:0]  mem_din,
    output logic          mem_mread,
    output logic          mem_mwrite,
    input  logic [S-1:0]  mem_dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] addr_q [D];
    logic [S-1:0]  data_q [D];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic full;
    logic push;
    logic drain;

    // A full buffer rejects the store even if the head drains this same
    // cycle; the CPU simply retries next cycle.
    assign full  = (cnt == CW'(D));
    assign push  = cpu_mwrite & ~full;
    assign drain = ~cpu_mread & (cnt != '0);

    assign stall = cpu_mwrite & full;
    assign empty = (cnt == '0);
    assign count = cnt;

    // Memory port arbitration: loads own the port, otherwise drain the head.
    always_comb begin
        mem_a      = '0;
        mem_din    = '0;
        mem_mread  = 1'b0;
        mem_mwrite = 1'b0;
        if (!reset) begin
            if (cpu_mread) begin
                mem_a     = cpu_a;
                mem_mread = 1'b1;
            end else if (cnt != '0) begin
                mem_a      = addr_q[head];
                mem_din    = data_q[head];
                mem_mwrite = 1'b1;
            end
        end
    end

    // Store-to-load forwarding: walk entries oldest to newest so the newest
    // match wins; entries pushed this cycle are not yet visible.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        cpu_dout = mem_dout;
        if (cpu_mread) begin
            for (int i = 0; i < D; i++) begin
                idx = head + PW'(i);
                if ((CW'(i) < cnt) && (addr_q[idx] == cpu_a)) begin
                    cpu_dout = data_q[idx];
                end
            end
        end
    end

    // FIFO control: pointers wrap modulo D, count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(drain);
        end
    end

    // Entry storage: payload only, validity is implied by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= cpu_a;
            data_q[tail] <= cpu_din;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer with a DataMemory model.
module tb_store_buffer;

    localparam int S  = 32;
    localparam int L  = 256;
    localparam int D  = 4;
    localparam int AW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_a;
    logic [S-1:0]  cpu_din;
    logic          cpu_mread;
    logic          cpu_mwrite;
    logic [S-1:0]  cpu_dout;
    logic          stall;
    logic [AW-1:0] mem_a;
    logic [S-1:0]  mem_din;
    logic          mem_mread;
    logic          mem_mwrite;
    logic [S-1:0]  mem_dout;
    logic          empty;
    logic [CW-1:0] count;

    logic          init_mem;
    logic [S-1:0]  dmem    [L];
    logic [S-1:0]  ref_mem [L];
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] exp_a;

    int errors = 0;
    int checks = 0;

    store_buffer #(.S(S), .L(L), .D(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_a      (cpu_a),
        .cpu_din    (cpu_din),
        .cpu_mread  (cpu_mread),
        .cpu_mwrite (cpu_mwrite),
        .cpu_dout   (cpu_dout),
        .stall      (stall),
        .mem_a      (mem_a),
        .mem_din    (mem_din),
        .mem_mread  (mem_mread),
        .mem_mwrite (mem_mwrite),
        .mem_dout   (mem_dout),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    // DataMemory model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < L; i++) dmem[i] <= 32'h5000_0000 | 32'(i);
        end else if (mem_mwrite) begin
            dmem[mem_a] <= mem_din;
        end
    end
    assign mem_dout = dmem[mem_a];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [S-1:0] d);
        cpu_mread  = rd;
        cpu_mwrite = wr;
        cpu_a      = a;
        cpu_din    = d;
        #1;
    endtask

    initial begin
        for (int i = 0; i < L; i++) ref_mem[i] = 32'h5000_0000 | 32'(i);
        reset = 1'b1; init_mem = 1'b1;
        cpu_a = '0; cpu_din = '0; cpu_mread = 1'b0; cpu_mwrite = 1'b0;
        tick(); tick();
        // Reset outputs, with a load request present
        drive(1'b1, 1'b0, 8'h33, 32'h0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mread", 32'(mem_mread), 32'd0);
        chk("rst_mwrite", 32'(mem_mwrite), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        init_mem = 1'b0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        // Test 1: reset mid-drain with 3 entries queued
        drive(1'b1, 1'b1, 8'h30, 32'hD000_0001); tick();
        drive(1'b1, 1'b1, 8'h31, 32'hD000_0002); tick();
        drive(1'b1, 1'b1, 8'h32, 32'hD000_0003); tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        chk("t1_count3", 32'(count), 32'd3);
        chk("t1_drain_we", 32'(mem_mwrite), 32'd1);
        chk("t1_drain_a", 32'(mem_a), 32'h30);
        reset = 1'b1;
        #1;
        chk("t1_rst_count", 32'(count), 32'd0);
        chk("t1_rst_empty", 32'(empty), 32'd1);
        chk("t1_rst_mwrite", 32'(mem_mwrite), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h30 + 8'(i), 32'h0);
            chk("t1_mem_kept", cpu_dout, 32'h5000_0030 + 32'(i));
        end

        // Test 2: store then load forwards; memory written afterwards
        drive(1'b0, 1'b1, 8'h10, 32'hAAAA_0001); tick();
        drive(1'b1, 1'b0, 8'h10, 32'h0);
        chk("t2_fwd", cpu_dout, 32'hAAAA_0001);
        chk("t2_no_write", 32'(mem_mwrite), 32'd0);
        chk("t2_mread", 32'(mem_mread), 32'd1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        chk("t2_drain_a", 32'(mem_a), 32'h10);
        chk("t2_drain_din", mem_din, 32'hAAAA_0001);
        tick();
        drive(1'b1, 1'b0, 8'h10, 32'h0);
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_mem", cpu_dout, 32'hAAAA_0001);
        ref_mem[8'h10] = 32'hAAAA_0001;

        // Test 3: three stores to one address while loading; newest wins
        drive(1'b1, 1'b1, 8'h20, 32'h1);
        chk("t3_pre_store", cpu_dout, 32'h5000_0020);
        tick();
        drive(1'b1, 1'b1, 8'h20, 32'h2);
        chk("t3_fwd1", cpu_dout, 32'h1);
        tick();
        drive(1'b1, 1'b1, 8'h20, 32'h3);
        chk("t3_fwd2", cpu_dout, 32'h2);
        tick();
        drive(1'b1, 1'b0, 8'h20, 32'h0);
        chk("t3_fwd3", cpu_dout, 32'h3);
        chk("t3_count", 32'(count), 32'd3);
        tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick(); tick(); tick();
        drive(1'b1, 1'b0, 8'h20, 32'h0);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_mem", cpu_dout, 32'h3);
        ref_mem[8'h20] = 32'h3;

        // Test 4: fill, stall, one drain, retry accepted
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'h40 + 8'(i), 32'h400 + 32'(i));
            chk("t4_fill_stall", 32'(stall), 32'd0);
            tick();
        end
        drive(1'b1, 1'b1, 8'h44, 32'h404);
        chk("t4_stall", 32'(stall), 32'd1);
        tick();
        chk("t4_count_full", 32'(count), 32'd4);
        drive(1'b0, 1'b1, 8'h44, 32'h404);
        chk("t4_stall_drain", 32'(stall), 32'd1);
        chk("t4_drain_a", 32'(mem_a), 32'h40);
        tick();
        chk("t4_count3", 32'(count), 32'd3);
        drive(1'b1, 1'b1, 8'h44, 32'h404);
        chk("t4_retry_stall", 32'(stall), 32'd0);
        tick();
        chk("t4_count4", 32'(count), 32'd4);
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick(); tick(); tick(); tick();
        chk("t4_empty", 32'(empty), 32'd1);
        drive(1'b1, 1'b0, 8'h44, 32'h0);
        chk("t4_mem44", cpu_dout, 32'h404);
        drive(1'b1, 1'b0, 8'h40, 32'h0);
        chk("t4_mem40", cpu_dout, 32'h400);
        for (int i = 0; i < 5; i++) ref_mem[8'h40 + 8'(i)] = 32'h400 + 32'(i);

        // Test 5: sustained stores, no loads
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 8'h50 + 8'(i), 32'h500 + 32'(i));
            chk("t5_stall", 32'(stall), 32'd0);
            if (i == 0) begin
                chk("t5_idle", 32'(mem_mwrite), 32'd0);
            end else begin
                chk("t5_we", 32'(mem_mwrite), 32'd1);
                chk("t5_mem_a", 32'(mem_a), 32'h50 + 32'(i) - 32'd1);
            end
            tick();
            chk("t5_count", 32'(count), 32'd1);
            ref_mem[8'h50 + 8'(i)] = 32'h500 + 32'(i);
        end
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        chk("t5_empty", 32'(empty), 32'd1);

        // Test 6: wrap-around with two entries in flight
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'h60 + 8'(i), 32'h600 + 32'(i));
            exp_q.push_back(8'h60 + 8'(i));
            ref_mem[8'h60 + 8'(i)] = 32'h600 + 32'(i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'h60 + 8'(i % 3), 32'h610 + 32'(i));
            exp_a = exp_q.pop_front();
            chk("t6_we", 32'(mem_mwrite), 32'd1);
            chk("t6_order", 32'(mem_a), 32'(exp_a));
            exp_q.push_back(8'h60 + 8'(i % 3));
            ref_mem[8'h60 + 8'(i % 3)] = 32'h610 + 32'(i);
            tick();
            chk("t6_count", 32'(count), 32'd2);
        end
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick(); tick();
        chk("t6_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h60 + 8'(i), 32'h0);
            chk("t6_mem", cpu_dout, ref_mem[8'h60 + 8'(i)]);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'h40 + 8'(i), 32'h0);
            chk("t6_mem_other", cpu_dout, ref_mem[8'h40 + 8'(i)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
